// File: rtl/dsp_ar_order_ctrl_if.sv
// Port bundle for the read-order sequencer: AR request side, slave-arbitration AR
// side, and the RDATA dispatcher channel taps and controls.
interface dsp_ar_order_ctrl_if #(
  parameter int SLV_AMT     = 2,
  parameter int LEN_W       = 8,
  parameter int OUTST_DEPTH = 4
) ();
  localparam int SLV_ID_W = $clog2(SLV_AMT);
  localparam int CNT_W    = $clog2(OUTST_DEPTH) + 1;

  // Handshakes are valid/ready: a transfer happens in a cycle where both are high;
  // valid never waits on ready.
  logic                ar_valid_i;
  logic [SLV_ID_W-1:0] ar_slv_id_i;
  logic [LEN_W-1:0]    ar_len_i;
  logic                ar_ready_o;
  logic [SLV_AMT-1:0]  sa_ARVALID_o;
  logic [SLV_AMT-1:0]  sa_ARREADY_i;
  logic                dsp_RVALID_q1_i;
  logic                dsp_RREADY_q1_i;
  logic                dsp_RLAST_q1_i;
  logic [SLV_ID_W-1:0] dsp_AR_slv_id_o;
  logic                dsp_AR_disable_o;
  logic [CNT_W-1:0]    outst_cnt_o;
  logic                rlast_err_o;

  modport slave (
    input  ar_valid_i, ar_slv_id_i, ar_len_i, sa_ARREADY_i,
           dsp_RVALID_q1_i, dsp_RREADY_q1_i, dsp_RLAST_q1_i,
    output ar_ready_o, sa_ARVALID_o, dsp_AR_slv_id_o, dsp_AR_disable_o,
           outst_cnt_o, rlast_err_o
  );

  modport master (
    output ar_valid_i, ar_slv_id_i, ar_len_i, sa_ARREADY_i,
           dsp_RVALID_q1_i, dsp_RREADY_q1_i, dsp_RLAST_q1_i,
    input  ar_ready_o, sa_ARVALID_o, dsp_AR_slv_id_o, dsp_AR_disable_o,
           outst_cnt_o, rlast_err_o
  );
endinterface

// File: rtl/dsp_ar_order_ctrl.sv
// Read-order sequencer: routes AR requests to slaves and keeps an in-order queue of
// {slave ID, ARLEN} whose head steers the RDATA dispatcher.
module dsp_ar_order_ctrl #(
  parameter int SLV_AMT     = 2,
  parameter int LEN_W       = 8,
  parameter int OUTST_DEPTH = 4
) (
  input  logic                ACLK_i,
  input  logic                ARESETn_i,
  dsp_ar_order_ctrl_if.slave  bus
);
  localparam int SLV_ID_W = $clog2(SLV_AMT);
  localparam int CNT_W    = $clog2(OUTST_DEPTH) + 1;
  localparam int PTR_W    = $clog2(OUTST_DEPTH);

  logic [SLV_ID_W-1:0] slv_id_q [OUTST_DEPTH];
  logic [SLV_ID_W-1:0] slv_id_d [OUTST_DEPTH];
  logic [LEN_W-1:0]    len_q    [OUTST_DEPTH];
  logic [LEN_W-1:0]    len_d    [OUTST_DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rlast_err_q, rlast_err_d;

  logic full, empty, id_ready, ar_hs, r_hs, last_beat, pop;

  assign full  = (cnt_q == CNT_W'(OUTST_DEPTH));
  assign empty = (cnt_q == '0);

  // Out-of-range IDs match no k, so they neither raise a valid nor see a ready.
  always_comb begin
    bus.sa_ARVALID_o = '0;
    id_ready         = 1'b0;
    for (int k = 0; k < SLV_AMT; k++) begin
      if (bus.ar_slv_id_i == SLV_ID_W'(k)) begin
        bus.sa_ARVALID_o[k] = bus.ar_valid_i & ~full;
        id_ready            = bus.sa_ARREADY_i[k];
      end
    end
  end

  assign bus.ar_ready_o = id_ready & ~full;
  assign ar_hs          = bus.ar_valid_i & bus.ar_ready_o;
  assign r_hs           = bus.dsp_RVALID_q1_i & bus.dsp_RREADY_q1_i & ~empty;
  assign last_beat      = (beat_cnt_q == len_q[rptr_q]);
  assign pop            = r_hs & last_beat;

  always_comb begin
    slv_id_d    = slv_id_q;
    len_d       = len_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    beat_cnt_d  = beat_cnt_q;
    cnt_d       = cnt_q;
    rlast_err_d = 1'b0;
    if (ar_hs) begin
      slv_id_d[wptr_q] = bus.ar_slv_id_i;
      len_d[wptr_q]    = bus.ar_len_i;
      wptr_d           = wptr_q + PTR_W'(1);
    end
    if (r_hs) begin
      // Retirement follows the beat count; RLAST only feeds the error flag.
      rlast_err_d = bus.dsp_RLAST_q1_i ^ last_beat;
      if (last_beat) begin
        beat_cnt_d = '0;
        rptr_d     = rptr_q + PTR_W'(1);
      end else begin
        beat_cnt_d = beat_cnt_q + LEN_W'(1);
      end
    end
    case ({ar_hs, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      for (int i = 0; i < OUTST_DEPTH; i++) begin
        slv_id_q[i] <= '0;
        len_q[i]    <= '0;
      end
      wptr_q      <= '0;
      rptr_q      <= '0;
      beat_cnt_q  <= '0;
      cnt_q       <= '0;
      rlast_err_q <= 1'b0;
    end else begin
      slv_id_q    <= slv_id_d;
      len_q       <= len_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      beat_cnt_q  <= beat_cnt_d;
      cnt_q       <= cnt_d;
      rlast_err_q <= rlast_err_d;
    end
  end

  assign bus.dsp_AR_slv_id_o  = slv_id_q[rptr_q];
  assign bus.dsp_AR_disable_o = empty;
  assign bus.outst_cnt_o      = cnt_q;
  assign bus.rlast_err_o      = rlast_err_q;
endmodule

// File: tb/tb_dsp_ar_order_ctrl.sv
// Directed bench for dsp_ar_order_ctrl: AR routing, in-order head, full rule,
// push/pop overlap, RLAST error pulses and asynchronous reset.
module tb_dsp_ar_order_ctrl;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  dsp_ar_order_ctrl_if #(.SLV_AMT(2), .LEN_W(8), .OUTST_DEPTH(4)) bus ();

  dsp_ar_order_ctrl #(.SLV_AMT(2), .LEN_W(8), .OUTST_DEPTH(4)) dut (
    .ACLK_i    (clk),
    .ARESETn_i (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic [7:0] len);
    bus.ar_valid_i   = 1'b1;
    bus.ar_slv_id_i  = id;
    bus.ar_len_i     = len;
    bus.sa_ARREADY_i = 2'b11;
    step();
    bus.ar_valid_i   = 1'b0;
  endtask

  task automatic beat(input logic last);
    bus.dsp_RVALID_q1_i = 1'b1;
    bus.dsp_RREADY_q1_i = 1'b1;
    bus.dsp_RLAST_q1_i  = last;
    step();
    bus.dsp_RVALID_q1_i = 1'b0;
    bus.dsp_RLAST_q1_i  = 1'b0;
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.ar_valid_i      = 1'b0;
    bus.ar_slv_id_i     = '0;
    bus.ar_len_i        = '0;
    bus.sa_ARREADY_i    = '0;
    bus.dsp_RVALID_q1_i = 1'b0;
    bus.dsp_RREADY_q1_i = 1'b0;
    bus.dsp_RLAST_q1_i  = 1'b0;
    repeat (3) step();
    chk("rst_cnt", 32'(bus.outst_cnt_o), 0);
    chk("rst_disable", 32'(bus.dsp_AR_disable_o), 1);
    chk("rst_head", 32'(bus.dsp_AR_slv_id_o), 0);
    chk("rst_err", 32'(bus.rlast_err_o), 0);
    rst_n = 1'b1;
    step();

    // Single AR to slave 1, len 3
    bus.ar_valid_i   = 1'b1;
    bus.ar_slv_id_i  = 1'b1;
    bus.ar_len_i     = 8'd3;
    bus.sa_ARREADY_i = 2'b10;
    #1;
    chk("route_arvalid", 32'(bus.sa_ARVALID_o), 2);
    chk("route_ready", 32'(bus.ar_ready_o), 1);
    step();
    bus.ar_valid_i = 1'b0;
    chk("push1_disable", 32'(bus.dsp_AR_disable_o), 0);
    chk("push1_head", 32'(bus.dsp_AR_slv_id_o), 1);
    chk("push1_cnt", 32'(bus.outst_cnt_o), 1);

    // Four beats, RLAST on the 4th
    for (int i = 0; i < 4; i++) begin
      beat(i == 3);
      chk("burst4_err", 32'(bus.rlast_err_o), 0);
      chk("burst4_cnt", 32'(bus.outst_cnt_o), (i == 3) ? 0 : 1);
    end
    chk("burst4_disable", 32'(bus.dsp_AR_disable_o), 1);

    // Fill with IDs 0,1,0,1, then check full blocking
    for (int i = 0; i < 4; i++) push(i[0], 8'd0);
    chk("fill_cnt", 32'(bus.outst_cnt_o), 4);
    bus.ar_valid_i  = 1'b1;
    bus.ar_slv_id_i = 1'b0;
    #1;
    chk("full_ready", 32'(bus.ar_ready_o), 0);
    chk("full_arvalid", 32'(bus.sa_ARVALID_o), 0);
    bus.ar_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("order_head", 32'(bus.dsp_AR_slv_id_o), i % 2);
      beat(1'b1);
    end
    chk("order_disable", 32'(bus.dsp_AR_disable_o), 1);
    chk("order_cnt", 32'(bus.outst_cnt_o), 0);

    // Full queue: final beat and AR in the same cycle, push refused
    for (int i = 0; i < 4; i++) push(i[0], 8'd0);
    bus.ar_valid_i      = 1'b1;
    bus.ar_slv_id_i     = 1'b1;
    bus.dsp_RVALID_q1_i = 1'b1;
    bus.dsp_RREADY_q1_i = 1'b1;
    bus.dsp_RLAST_q1_i  = 1'b1;
    #1;
    chk("fullpop_ready", 32'(bus.ar_ready_o), 0);
    step();
    bus.dsp_RVALID_q1_i = 1'b0;
    chk("fullpop_cnt", 32'(bus.outst_cnt_o), 3);
    chk("fullpop_head", 32'(bus.dsp_AR_slv_id_o), 1);
    chk("retry_ready", 32'(bus.ar_ready_o), 1);
    step();
    bus.ar_valid_i = 1'b0;
    chk("retry_cnt", 32'(bus.outst_cnt_o), 4);
    // Queue now holds 1,0,1,1
    for (int i = 0; i < 4; i++) begin
      chk("drain_head", 32'(bus.dsp_AR_slv_id_o), (i == 1) ? 0 : 1);
      beat(1'b1);
    end
    chk("drain_cnt", 32'(bus.outst_cnt_o), 0);

    // cnt=2, push and pop in the same cycle
    push(1'b0, 8'd0);
    push(1'b1, 8'd1);
    chk("pp_pre_cnt", 32'(bus.outst_cnt_o), 2);
    bus.ar_valid_i      = 1'b1;
    bus.ar_slv_id_i     = 1'b0;
    bus.ar_len_i        = 8'd0;
    bus.dsp_RVALID_q1_i = 1'b1;
    bus.dsp_RREADY_q1_i = 1'b1;
    bus.dsp_RLAST_q1_i  = 1'b1;
    step();
    bus.ar_valid_i      = 1'b0;
    bus.dsp_RVALID_q1_i = 1'b0;
    chk("pp_cnt", 32'(bus.outst_cnt_o), 2);
    chk("pp_head", 32'(bus.dsp_AR_slv_id_o), 1);
    beat(1'b0);
    chk("pp_b0_cnt", 32'(bus.outst_cnt_o), 2);
    beat(1'b1);
    chk("pp_b1_cnt", 32'(bus.outst_cnt_o), 1);
    chk("pp_b1_head", 32'(bus.dsp_AR_slv_id_o), 0);
    chk("pp_b1_err", 32'(bus.rlast_err_o), 0);
    beat(1'b1);
    chk("pp_empty", 32'(bus.dsp_AR_disable_o), 1);

    // RLAST errors on a 2-beat burst
    push(1'b1, 8'd1);
    beat(1'b1);
    chk("err_early", 32'(bus.rlast_err_o), 1);
    chk("err_early_cnt", 32'(bus.outst_cnt_o), 1);
    beat(1'b0);
    chk("err_missing", 32'(bus.rlast_err_o), 1);
    chk("err_missing_cnt", 32'(bus.outst_cnt_o), 0);
    step();
    chk("err_clear", 32'(bus.rlast_err_o), 0);

    // Reset in the middle of a burst
    push(1'b1, 8'd3);
    beat(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", 32'(bus.outst_cnt_o), 0);
    chk("mid_rst_disable", 32'(bus.dsp_AR_disable_o), 1);
    chk("mid_rst_head", 32'(bus.dsp_AR_slv_id_o), 0);
    step();
    rst_n = 1'b1;
    step();
    push(1'b0, 8'd0);
    chk("post_rst_cnt", 32'(bus.outst_cnt_o), 1);
    chk("post_rst_head", 32'(bus.dsp_AR_slv_id_o), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dsp_ar_order_ctrl.md
Name: dsp_ar_order_ctrl

Overview:
Read-order sequencer for one master port of the interconnect dispatcher. It routes each accepted AR request to the slave selected by the decoded slave ID and records that slave ID and ARLEN in an in-order outstanding queue. The queue head drives the slave-select and disable inputs of the RDATA dispatcher channel, so R beats return to the master in AR issue order. The block counts R beats, retires the head entry on the final beat, and flags RLAST mismatches.

Parameters:
SLV_AMT, 2, number of slaves
SLV_ID_W, $clog2(SLV_AMT), slave ID width
LEN_W, 8, AXI4 ARLEN width
OUTST_DEPTH, 4, maximum outstanding read bursts (power of two, ≥2)
CNT_W, $clog2(OUTST_DEPTH)+1, outstanding count width

Ports:
ACLK_i  in  1  clock
ARESETn_i  in  1  asynchronous active-low reset
ar_valid_i  in  1  master AR valid (post-decode)
ar_slv_id_i  in  SLV_ID_W  decoded target slave
ar_len_i  in  LEN_W  ARLEN (beats−1)
ar_ready_o  out  1  AR accepted
sa_ARVALID_o  out  SLV_AMT  one-hot AR valid to slave arbitration
sa_ARREADY_i  in  SLV_AMT  AR ready from slave arbitration
dsp_RVALID_q1_i  in  1  RDATA channel skid-buffer input valid
dsp_RREADY_q1_i  in  1  RDATA channel skid-buffer input ready
dsp_RLAST_q1_i  in  1  RLAST of beat at skid-buffer input
dsp_AR_slv_id_o  out  SLV_ID_W  head slave ID to RDATA channel
dsp_AR_disable_o  out  1  queue empty, blocks RDATA selection
outst_cnt_o  out  CNT_W  entries in queue
rlast_err_o  out  1  one-cycle RLAST mismatch pulse

Behaviour:
- Single clock ACLK_i; ARESETn_i asynchronous assert, synchronous deassert assumed upstream.
- Reset state: queue empty, write and read pointers 0, beat counter 0, outst_cnt_o=0, dsp_AR_disable_o=1, dsp_AR_slv_id_o=0, rlast_err_o=0.
- full = (outst_cnt == OUTST_DEPTH); empty = (outst_cnt == 0).
- AR routing (combinational):
  - sa_ARVALID_o[k] = ar_valid_i & ~full & (ar_slv_id_i==k).
  - ar_ready_o = sa_ARREADY_i[ar_slv_id_i] & ~full.
  - ar_slv_id_i ≥ SLV_AMT gives sa_ARVALID_o=0 and ar_ready_o=0; upstream decode guarantees a legal ID.
- Push: ar_hs = ar_valid_i & ar_ready_o. Writes {ar_slv_id_i, ar_len_i} at wptr. wptr wraps modulo OUTST_DEPTH.
- Full rule: no push while full, even if a pop occurs in the same cycle (no bypass).
- Head (registered queue storage, read combinationally at rptr):
  - dsp_AR_slv_id_o = slv_id[rptr]; dsp_AR_disable_o = empty.
  - A push into an empty queue clears dsp_AR_disable_o on the next cycle (1-cycle AR→R-select latency).
- Beat tracking:
  - r_hs = dsp_RVALID_q1_i & dsp_RREADY_q1_i & ~empty.
  - On r_hs with beat_cnt ≠ len[rptr]: beat_cnt increments.
  - On r_hs with beat_cnt == len[rptr]: pop (rptr wraps), beat_cnt ← 0.
  - r_hs while empty is ignored; the RDATA channel cannot produce it because disable is high.
- Counter: push only → +1; pop only → −1; push and pop together → unchanged. outst_cnt_o is registered.
- Head update on pop: the new head appears the cycle after the final beat. An RDATA beat in that same cycle uses the new slave ID.
- RLAST check on each r_hs: mismatch = dsp_RLAST_q1_i XOR (beat_cnt == len[rptr]).
  - rlast_err_o is registered high for one cycle after a mismatch.
  - Retirement follows beat count only, never RLAST.
- ARLEN=0: single-beat burst; pops on its first beat.
- Reset mid-burst clears all state immediately. In-flight beats are dropped; system-level reset covers this.

Test Plan:
- Reset, then ar_valid_i=1, ar_slv_id_i=1, ar_len_i=3, sa_ARREADY_i=2'b10 → sa_ARVALID_o=2'b10, ar_ready_o=1. Next cycle dsp_AR_disable_o=0, dsp_AR_slv_id_o=1, outst_cnt_o=1.
- Four R handshakes with RLAST only on the 4th → pop after 4th; dsp_AR_disable_o=1 next cycle, rlast_err_o stays 0.
- Push IDs 0,1,0,1 (len 0 each) with no R → outst_cnt_o=4, ar_ready_o=0, sa_ARVALID_o=0. Single-beat returns present IDs 0,1,0,1 in order, then empty.
- Full queue, same cycle R final beat and ar_valid_i=1 → push refused; outst_cnt_o=3. AR accepted the following cycle → outst_cnt_o=4.
- Non-full queue (cnt=2), simultaneous push and final-beat pop → outst_cnt_o remains 2, head advances to the next entry.
- len=1, RLAST=1 on beat 0 → rlast_err_o pulses 1 cycle. Entry pops only after beat 1; the second beat (RLAST=0) pulses rlast_err_o again.
